nav_fsm: RTL and testbench

NAV_FSM -- requirements
Module: nav_fsm

---
 rtl/nav_fsm.sv | 151 +++++++++++++++
 tb/tb_nav_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nav_fsm.sv
// Obstacle-avoiding navigation controller: synchronized and debounced sensors
// feed a Moore FSM that drives forward, rotate-right, rotate-left and stuck outputs.
module nav_fsm #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned ROT_CYCLES = 50,
  parameter int unsigned MAX_TENT   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic Liga,
  input  logic ObsF,
  input  logic ObsR,
  input  logic ObsL,
  output logic Frente,
  output logic RotR,
  output logic RotL,
  output logic Erro
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRENTE,
    S_ROT_R,
    S_ROT_L,
    S_ERRO
  } state_t;

  localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] ROT_LAST = 16'(ROT_CYCLES - 1);
  localparam logic [3:0]  TENT_MAX = 4'(MAX_TENT);

  state_t      state_q, state_d;
  logic [15:0] rot_q, rot_d;
  logic [3:0]  tent_q, tent_d;
  logic        alt_q, alt_d;

  // Sensor vectors are ordered {front, right, left}
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  deb_q, deb_d;
  logic [7:0]  debcnt_q [3];
  logic [7:0]  debcnt_d [3];

  logic        front, right, left;
  logic        frente_d, rotr_d, rotl_d, erro_d;

  assign front = deb_q[2];
  assign right = deb_q[1];
  assign left  = deb_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rot_q    <= '0;
      tent_q   <= '0;
      alt_q    <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      debcnt_q <= '{default: '0};
      Frente   <= 1'b0;
      RotR     <= 1'b0;
      RotL     <= 1'b0;
      Erro     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rot_q    <= rot_d;
      tent_q   <= tent_d;
      alt_q    <= alt_d;
      sync1_q  <= {ObsF, ObsR, ObsL};
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      debcnt_q <= debcnt_d;
      Frente   <= frente_d;
      RotR     <= rotr_d;
      RotL     <= rotl_d;
      Erro     <= erro_d;
    end
  end

  // A sensor flips only after DEB_CYCLES consecutive disagreeing samples
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < 3; i++) begin
      debcnt_d[i[1:0]] = '0;
      if (sync2_q[i[1:0]] != deb_q[i[1:0]]) begin
        if (debcnt_q[i[1:0]] == DEB_LAST) begin
          deb_d[i[1:0]] = sync2_q[i[1:0]];
        end else begin
          debcnt_d[i[1:0]] = debcnt_q[i[1:0]] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    tent_d  = tent_q;
    alt_d   = alt_q;
    if (!Liga) begin
      state_d = S_IDLE;
      tent_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_FRENTE;
          tent_d  = '0;
        end
        S_FRENTE: begin
          if (front) begin
            rot_d = ROT_LAST;
            if (right && left) begin
              state_d = alt_q ? S_ROT_L : S_ROT_R;
              alt_d   = ~alt_q;
            end else if (right) begin
              state_d = S_ROT_L;
            end else begin
              state_d = S_ROT_R;
            end
          end
        end
        S_ROT_R, S_ROT_L: begin
          if (rot_q != '0) begin
            rot_d = rot_q - 16'd1;
          end else if (!front) begin
            state_d = S_FRENTE;
            tent_d  = '0;
          end else begin
            // Failed attempt: retry in the same direction until the limit
            tent_d = tent_q + 4'd1;
            if (tent_q + 4'd1 == TENT_MAX) begin
              state_d = S_ERRO;
            end else begin
              rot_d = ROT_LAST;
            end
          end
        end
        S_ERRO: state_d = S_ERRO;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    frente_d = (state_d == S_FRENTE);
    rotr_d   = (state_d == S_ROT_R);
    rotl_d   = (state_d == S_ROT_L);
    erro_d   = (state_d == S_ERRO);
  end

endmodule

// File: tb/tb_nav_fsm.sv
// Bench for nav_fsm: directed obstacle scenarios with literal timing checks,
// plus a per-cycle behavioural model compared against the outputs.
module tb_nav_fsm;
  localparam int DEB  = 4;
  localparam int ROT  = 8;
  localparam int MAXT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Liga = 1'b0;
  logic ObsF = 1'b0;
  logic ObsR = 1'b0;
  logic ObsL = 1'b0;
  logic Frente, RotR, RotL, Erro;

  int total = 0;
  int bad   = 0;

  nav_fsm #(.DEB_CYCLES(DEB), .ROT_CYCLES(ROT), .MAX_TENT(MAXT)) dut (
    .clk(clk), .reset(reset), .Liga(Liga),
    .ObsF(ObsF), .ObsR(ObsR), .ObsL(ObsL),
    .Frente(Frente), .RotR(RotR), .RotL(RotL), .Erro(Erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {F,R,L,E}=%b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 forward, 2 turning right, 3 turning left, 4 stuck.
  // Sensor index 0 front, 1 right, 2 left.
  int   m_mode, m_elapsed, m_tries;
  bit   m_alt;
  bit   m_seen [3];
  int   m_run [3];
  bit   m_d1 [3];
  bit   m_d2 [3];
  bit   raw [3];
  bit   m_valid = 1'b0;
  logic [3:0] m_exp = '0;

  always @(posedge clk) begin
    raw = '{ObsF, ObsR, ObsL};
    if (reset) begin
      m_mode = 0; m_elapsed = 0; m_tries = 0; m_alt = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_seen[i] = 1'b0; m_run[i] = 0; m_d1[i] = 1'b0; m_d2[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      if (!Liga) begin
        m_mode = 0; m_tries = 0;
      end else begin
        case (m_mode)
          0: m_mode = 1;
          1: if (m_seen[0]) begin
               m_elapsed = 1;
               if (m_seen[1] && m_seen[2]) begin
                 m_mode = m_alt ? 3 : 2;
                 m_alt = !m_alt;
               end else if (m_seen[1]) m_mode = 3;
               else m_mode = 2;
             end
          2, 3: if (m_elapsed < ROT) m_elapsed++;
                else if (!m_seen[0]) begin m_mode = 1; m_tries = 0; end
                else begin
                  m_tries++;
                  if (m_tries == MAXT) m_mode = 4;
                  else m_elapsed = 1;
                end
          default: ;
        endcase
      end
      for (int i = 0; i < 3; i++) begin
        if (m_d2[i] != m_seen[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_seen[i] = m_d2[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
    case (m_mode)
      1: m_exp = 4'b1000;
      2: m_exp = 4'b0100;
      3: m_exp = 4'b0010;
      4: m_exp = 4'b0001;
      default: m_exp = 4'b0000;
    endcase
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model", {Frente, RotR, RotL, Erro}, m_exp);
      total++;
      if ($countones({Frente, RotR, RotL}) > 1) begin
        bad++;
        $display("FAIL onehot: got F,R,L=%b%b%b required at most one set", Frente, RotR, RotL);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic want(input string name, input logic [3:0] exp);
    chk(name, {Frente, RotR, RotL, Erro}, exp);
  endtask

  initial begin
    tick(3);
    want("reset_outputs", 4'b0000);
    reset = 1'b0; Liga = 1'b1;
    tick(1);            want("liga_to_frente", 4'b1000);

    ObsF = 1'b1;
    tick(6);            want("front_cycle6_still_fwd", 4'b1000);
    tick(1);            want("front_cycle7_rotr", 4'b0100);
    ObsF = 1'b0;
    tick(7);            want("rotr_last_cycle", 4'b0100);
    tick(1);            want("rot_done_frente", 4'b1000);

    ObsF = 1'b1; tick(3); ObsF = 1'b0;
    tick(12);           want("pulse3_ignored", 4'b1000);
    ObsF = 1'b1; tick(4); ObsF = 1'b0;
    tick(3);            want("pulse4_rotr", 4'b0100);
    tick(7);            want("pulse4_rot_last", 4'b0100);
    tick(1);            want("pulse4_back_fwd", 4'b1000);

    ObsF = 1'b1; ObsR = 1'b1;
    tick(7);            want("right_blocked_rotl", 4'b0010);
    ObsF = 1'b0; ObsR = 1'b0;
    tick(8);            want("rotl_back_fwd", 4'b1000);

    ObsF = 1'b1; ObsR = 1'b1; ObsL = 1'b1;
    tick(7);            want("both_first_rotr", 4'b0100);
    ObsF = 1'b0;
    tick(8);            want("both_first_back", 4'b1000);
    ObsF = 1'b1;
    tick(7);            want("both_second_rotl", 4'b0010);
    ObsF = 1'b0; ObsR = 1'b0; ObsL = 1'b0;
    tick(8);            want("both_second_back", 4'b1000);

    ObsF = 1'b1;
    tick(7);            want("stuck_rot_start", 4'b0100);
    tick(23);           want("stuck_rot_24th", 4'b0100);
    tick(1);            want("stuck_erro", 4'b0001);
    tick(5);            want("erro_held", 4'b0001);
    Liga = 1'b0;
    tick(1);            want("erro_liga_off_idle", 4'b0000);
    ObsF = 1'b0;
    tick(8);            want("idle_held", 4'b0000);
    Liga = 1'b1;
    tick(1);            want("relaunch_frente", 4'b1000);

    ObsF = 1'b1; ObsR = 1'b1; ObsL = 1'b1;
    tick(7);            want("pre_reset_rotr", 4'b0100);
    tick(2);
    reset = 1'b1;
    tick(1);            want("reset_mid_rot", 4'b0000);
    reset = 1'b0;
    tick(1);            want("post_reset_frente", 4'b1000);
    tick(5);            want("post_reset_debounce", 4'b1000);
    tick(1);            want("post_reset_alt_r", 4'b0100);

    Liga = 1'b0; ObsF = 1'b0; ObsR = 1'b0; ObsL = 1'b0;
    tick(2);            want("final_idle", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
